// File: rtl/object_pkg.sv
// Shared types for the streaming object extractor.
// Provides the coordinate/area widths, the object record written to the
// per-frame object buffer, the per-slot tracking state, the FSM state type
// and small min/max helpers.
package object_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned AREA_W  = 20;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t              x_min;
    coord_t              x_max;
    coord_t              y_min;
    coord_t              y_max;
    logic [AREA_W-1:0]   area;
  } object_t;

  // prev_* describe the object's extent in the last completed row (prev_ne
  // says whether that row held any of it); cur_* accumulate the current row.
  typedef struct packed {
    logic    valid;
    logic    touched;
    logic    prev_ne;
    coord_t  prev_lo;
    coord_t  prev_hi;
    coord_t  cur_lo;
    coord_t  cur_hi;
    object_t obj;
  } slot_t;

  typedef enum logic [1:0] {StIdle, StActive, StScan, StFlush} state_e;

  function automatic coord_t coord_min(coord_t a, coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t coord_max(coord_t a, coord_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/object_extractor_if.sv
// Pixel-stream / object-buffer bundle for object_extractor.
// master: the upstream/test side driving frame_start, pix_valid, pix_mask,
//         line_end, frame_end, buf_full and observing the outputs.
// slave:  the extractor, consuming the stream and producing obj_data,
//         obj_write, busy and frame_done.
interface object_extractor_if;
  import object_pkg::*;

  logic    frame_start;
  logic    pix_valid;
  logic    pix_mask;
  logic    line_end;
  logic    frame_end;
  logic    buf_full;
  object_t obj_data;
  logic    obj_write;
  logic    busy;
  logic    frame_done;

  modport master (
    output frame_start, pix_valid, pix_mask, line_end, frame_end, buf_full,
    input  obj_data, obj_write, busy, frame_done
  );

  modport slave (
    input  frame_start, pix_valid, pix_mask, line_end, frame_end, buf_full,
    output obj_data, obj_write, busy, frame_done
  );

endinterface

// File: rtl/run_detector.sv
// Horizontal run detector for the object extractor.
// Counts valid pixels along a row (x, saturating, cleared by line_end or
// clear) and reports each closed run of set pixels as a one-cycle
// run_valid with registered run_lo/run_hi. Gaps in pix_valid do not break a
// run; a run still open at line_end is closed there.
// Ports: clock, reset (async, active-high), clear (frame start), enable,
//        pix_valid, pix_mask, line_end -> run_valid, run_lo, run_hi.
module run_detector
  import object_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   clear,
  input  logic   enable,
  input  logic   pix_valid,
  input  logic   pix_mask,
  input  logic   line_end,
  output logic   run_valid,
  output coord_t run_lo,
  output coord_t run_hi
);

  coord_t x_q;
  coord_t open_lo_q;
  coord_t open_hi_q;
  logic   in_run_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q       <= '0;
      open_lo_q <= '0;
      open_hi_q <= '0;
      in_run_q  <= 1'b0;
      run_valid <= 1'b0;
      run_lo    <= '0;
      run_hi    <= '0;
    end else begin
      run_valid <= 1'b0;
      if (clear) begin
        x_q      <= '0;
        in_run_q <= 1'b0;
      end else if (enable) begin
        if (line_end) begin
          x_q      <= '0;
          in_run_q <= 1'b0;
          if (in_run_q) begin
            run_valid <= 1'b1;
            run_lo    <= open_lo_q;
            run_hi    <= open_hi_q;
          end
        end else if (pix_valid) begin
          if (x_q != '1) x_q <= x_q + 1'b1;
          if (pix_mask) begin
            if (!in_run_q) begin
              in_run_q  <= 1'b1;
              open_lo_q <= x_q;
            end
            // Track the last set pixel so the run end is exact even at x saturation.
            open_hi_q <= x_q;
          end else if (in_run_q) begin
            in_run_q  <= 1'b0;
            run_valid <= 1'b1;
            run_lo    <= open_lo_q;
            run_hi    <= open_hi_q;
          end
        end
      end
    end
  end

endmodule

// File: rtl/object_extractor.sv
// Streaming connected-component extractor.
// Groups runs from run_detector into 8-connected objects held in NSLOTS
// slots, tracking bounding box and area. After each line_end the slots are
// scanned one per cycle: objects not continued in the finished row are
// emitted (if area >= MIN_AREA and the buffer is not full) and freed.
// frame_end flushes every open object the same way, then frame_done pulses.
// Ports: clock, reset (async, active-high), bus (object_extractor_if.slave).
// Optional: define OBJECT_EXTRACTOR_STATS_EN to add dropped_runs and
// dropped_objects saturating 16-bit counters.
module object_extractor
  import object_pkg::*;
#(
  parameter int unsigned NSLOTS   = 8,
  parameter int unsigned MIN_AREA = 4
) (
  input  logic                clock,
  input  logic                reset,
  object_extractor_if.slave   bus
`ifdef OBJECT_EXTRACTOR_STATS_EN
  ,
  output logic [15:0]         dropped_runs,
  output logic [15:0]         dropped_objects
`endif
);

  localparam int unsigned IdxW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int unsigned CntW = $clog2(NSLOTS + 2);
  localparam logic [CntW-1:0] CntLast = CntW'(NSLOTS + 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  coord_t          y_q;
  coord_t          run_row_q;
  slot_t           slots_q [NSLOTS];
  logic            obj_write_q;
  object_t         obj_data_q;
  logic            busy_q;
  logic            frame_done_q;

  logic            run_valid;
  coord_t          run_lo;
  coord_t          run_hi;

  logic            match_found;
  logic            free_found;
  logic [IdxW-1:0] match_idx;
  logic [IdxW-1:0] free_idx;
  slot_t           hit;
  slot_t           absorbed;
  slot_t           fresh;
  logic [AREA_W-1:0] run_len;

  logic            examining;
  logic [IdxW-1:0] exam_idx;
  slot_t           exam;
  logic            emit_now;
  logic            qualifies;

`ifdef OBJECT_EXTRACTOR_STATS_EN
  logic [15:0] drop_runs_q;
  logic [15:0] drop_objs_q;
  assign dropped_runs    = drop_runs_q;
  assign dropped_objects = drop_objs_q;
`endif

  assign bus.obj_write  = obj_write_q;
  assign bus.obj_data   = obj_data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

  run_detector u_run_detector (
    .clock     (clock),
    .reset     (reset),
    .clear     (bus.frame_start),
    .enable    (state_q == StActive),
    .pix_valid (bus.pix_valid),
    .pix_mask  (bus.pix_mask),
    .line_end  (bus.line_end),
    .run_valid (run_valid),
    .run_lo    (run_lo),
    .run_hi    (run_hi)
  );

  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int unsigned i = 0; i < NSLOTS; i++) begin
      // 8-connectivity: overlap with the previous row widened by one pixel each side.
      if (!match_found && slots_q[i].valid && slots_q[i].prev_ne &&
          ({1'b0, run_lo} <= {1'b0, slots_q[i].prev_hi} + 1'b1) &&
          ({1'b0, run_hi} + 1'b1 >= {1'b0, slots_q[i].prev_lo})) begin
        match_found = 1'b1;
        match_idx   = IdxW'(i);
      end
      if (!free_found && !slots_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end

    run_len = AREA_W'(run_hi - run_lo) + 1'b1;

    hit      = slots_q[match_idx];
    absorbed = hit;
    absorbed.touched   = 1'b1;
    // First run of a new row replaces the stale extent; later runs widen it.
    absorbed.cur_lo    = hit.touched ? coord_min(hit.cur_lo, run_lo) : run_lo;
    absorbed.cur_hi    = hit.touched ? coord_max(hit.cur_hi, run_hi) : run_hi;
    absorbed.obj.x_min = coord_min(hit.obj.x_min, run_lo);
    absorbed.obj.x_max = coord_max(hit.obj.x_max, run_hi);
    absorbed.obj.y_max = coord_max(hit.obj.y_max, run_row_q);
    absorbed.obj.area  = hit.obj.area + run_len;

    fresh         = '0;
    fresh.valid   = 1'b1;
    fresh.touched = 1'b1;
    fresh.cur_lo  = run_lo;
    fresh.cur_hi  = run_hi;
    fresh.obj     = '{x_min: run_lo, x_max: run_hi, y_min: run_row_q, y_max: run_row_q,
                      area: run_len};
  end

  assign examining = ((state_q == StScan) || (state_q == StFlush)) &&
                     (cnt_q != '0) && (cnt_q <= CntW'(NSLOTS));
  assign exam_idx  = IdxW'(cnt_q - 1'b1);
  assign exam      = slots_q[exam_idx];
  assign emit_now  = exam.valid && ((state_q == StFlush) || !exam.touched);
  assign qualifies = exam.obj.area >= AREA_W'(MIN_AREA);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      y_q          <= '0;
      run_row_q    <= '0;
      obj_write_q  <= 1'b0;
      obj_data_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int unsigned i = 0; i < NSLOTS; i++) slots_q[i] <= '0;
`ifdef OBJECT_EXTRACTOR_STATS_EN
      drop_runs_q  <= '0;
      drop_objs_q  <= '0;
`endif
    end else begin
      obj_write_q  <= 1'b0;
      frame_done_q <= 1'b0;
      // Row of the run reported by run_detector this cycle (y may have advanced).
      run_row_q    <= y_q;
      if (bus.frame_start) begin
        state_q <= StActive;
        cnt_q   <= '0;
        y_q     <= '0;
        busy_q  <= 1'b0;
        for (int unsigned i = 0; i < NSLOTS; i++) begin
          slots_q[i].valid   <= 1'b0;
          slots_q[i].touched <= 1'b0;
        end
`ifdef OBJECT_EXTRACTOR_STATS_EN
        drop_runs_q <= '0;
        drop_objs_q <= '0;
`endif
      end else begin
        if (run_valid) begin
          if (match_found) begin
            slots_q[match_idx] <= absorbed;
          end else if (free_found) begin
            slots_q[free_idx] <= fresh;
          end else begin
`ifdef OBJECT_EXTRACTOR_STATS_EN
            if (drop_runs_q != '1) drop_runs_q <= drop_runs_q + 1'b1;
`endif
          end
        end
        unique case (state_q)
          StActive: begin
            if (bus.line_end) begin
              state_q <= StScan;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              if (y_q != '1) y_q <= y_q + 1'b1;
            end else if (bus.frame_end) begin
              // Flush skips the run-settling cycle: slot 0 is examined next cycle.
              state_q <= StFlush;
              cnt_q   <= CntW'(1);
              busy_q  <= 1'b1;
            end
          end
          StScan, StFlush: begin
            if (examining && exam.valid) begin
              slots_q[exam_idx].touched <= 1'b0;
              if (emit_now) begin
                slots_q[exam_idx].valid <= 1'b0;
                if (qualifies) begin
                  if (!bus.buf_full) begin
                    obj_write_q <= 1'b1;
                    obj_data_q  <= exam.obj;
                  end else begin
`ifdef OBJECT_EXTRACTOR_STATS_EN
                    if (drop_objs_q != '1) drop_objs_q <= drop_objs_q + 1'b1;
`endif
                  end
                end
              end else begin
                slots_q[exam_idx].prev_lo <= exam.cur_lo;
                slots_q[exam_idx].prev_hi <= exam.cur_hi;
                slots_q[exam_idx].prev_ne <= 1'b1;
              end
            end
            if (cnt_q == CntLast) begin
              state_q      <= (state_q == StScan) ? StActive : StIdle;
              busy_q       <= 1'b0;
              frame_done_q <= (state_q == StFlush);
              cnt_q        <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_object_extractor.sv
// Self-checking bench for object_extractor: two instances (MIN_AREA 1 and 4)
// see the same stimulus; expected records are queued per instance and
// popped as writes appear.
module tb_object_extractor;
  import object_pkg::*;

  localparam int unsigned NS = 8;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0, pix_valid = 1'b0, pix_mask = 1'b0;
  logic line_end = 1'b0, frame_end = 1'b0, buf_full = 1'b0;

  always #5 clock = ~clock;

  object_extractor_if if_a ();
  object_extractor_if if_b ();

  assign if_a.frame_start = frame_start;
  assign if_a.pix_valid   = pix_valid;
  assign if_a.pix_mask    = pix_mask;
  assign if_a.line_end    = line_end;
  assign if_a.frame_end   = frame_end;
  assign if_a.buf_full    = buf_full;
  assign if_b.frame_start = frame_start;
  assign if_b.pix_valid   = pix_valid;
  assign if_b.pix_mask    = pix_mask;
  assign if_b.line_end    = line_end;
  assign if_b.frame_end   = frame_end;
  assign if_b.buf_full    = buf_full;

`ifdef OBJECT_EXTRACTOR_STATS_EN
  logic [15:0] dr_a, do_a, dr_b, do_b;
`endif

  object_extractor #(.NSLOTS(NS), .MIN_AREA(1)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (if_a)
`ifdef OBJECT_EXTRACTOR_STATS_EN
    ,
    .dropped_runs    (dr_a),
    .dropped_objects (do_a)
`endif
  );

  object_extractor #(.NSLOTS(NS), .MIN_AREA(4)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (if_b)
`ifdef OBJECT_EXTRACTOR_STATS_EN
    ,
    .dropped_runs    (dr_b),
    .dropped_objects (do_b)
`endif
  );

  typedef struct {
    object_t obj;
    int      cyc;
  } exp_t;

  typedef struct {
    int      x0;
    int      w;
    int      y0;
    int      h;
    object_t exp;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic object_t mk(int x0, int x1, int y0, int y1, int a);
    object_t o;
    o.x_min = COORD_W'(x0);
    o.x_max = COORD_W'(x1);
    o.y_min = COORD_W'(y0);
    o.y_max = COORD_W'(y1);
    o.area  = AREA_W'(a);
    return o;
  endfunction

  function automatic logic [31:0] rmask(int x0, int w);
    logic [31:0] m;
    m = ((32'd1 << w) - 32'd1) << x0;
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input object_t o, input int c);
    exp_t e;
    e.obj = o;
    e.cyc = c;
    q_a.push_back(e);
    if (o.area >= 4) q_b.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    if (if_a.obj_write) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write_a: got %0h want no write (cycle %0d)", if_a.obj_data, cyc);
      end else begin
        e = q_a.pop_front();
        check("obj_data_a", if_a.obj_data, e.obj);
        check("write_cycle_a", 64'(cyc), 64'(e.cyc));
      end
    end
    if (if_b.obj_write) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write_b: got %0h want no write (cycle %0d)", if_b.obj_data, cyc);
      end else begin
        e = q_b.pop_front();
        check("obj_data_b", if_b.obj_data, e.obj);
        check("write_cycle_b", 64'(cyc), 64'(e.cyc));
      end
    end
  endtask

  // Sample on the falling edge, then step to just after the next rising edge.
  task automatic tick();
    @(negedge clock);
    monitor();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic blank(input int n);
    repeat (n) tick();
  endtask

  task automatic pixels(input logic [31:0] bits, input int gap_at);
    for (int x = 0; x < W; x++) begin
      if (x == gap_at) begin
        pix_valid = 1'b0;
        tick();
      end
      pix_valid = 1'b1;
      pix_mask  = bits[x];
      tick();
    end
    pix_valid = 1'b0;
    pix_mask  = 1'b0;
  endtask

  task automatic line();
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
  endtask

  task automatic row(input logic [31:0] bits);
    pixels(bits, -1);
    line();
    blank(NS + 4);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    blank(NS + 4);
  endtask

  vec_t vecs[4];

  initial begin
    int t;
    logic [31:0] m;

    vecs[0] = '{x0: 10, w: 3, y0: 5, h: 2, exp: mk(10, 12, 5, 6, 6)};
    vecs[1] = '{x0: 0,  w: 1, y0: 0, h: 1, exp: mk(0, 0, 0, 0, 1)};
    vecs[2] = '{x0: 28, w: 4, y0: 1, h: 1, exp: mk(28, 31, 1, 1, 4)};
    vecs[3] = '{x0: 5,  w: 1, y0: 2, h: 3, exp: mk(5, 5, 2, 4, 3)};

    // Reset state.
    blank(2);
    check("reset_write_a", 64'(if_a.obj_write), 64'd0);
    check("reset_busy_a", 64'(if_a.busy), 64'd0);
    check("reset_done_a", 64'(if_a.frame_done), 64'd0);
    check("reset_data_a", if_a.obj_data, 64'd0);
    check("reset_write_b", 64'(if_b.obj_write), 64'd0);
    check("reset_busy_b", 64'(if_b.busy), 64'd0);
    reset = 1'b0;
    tick();

    // Single rectangles, emitted in the scan after the row below them.
    for (int v = 0; v < 4; v++) begin
      start_frame();
      for (int y = 0; y <= vecs[v].y0 + vecs[v].h; y++) begin
        if (y == vecs[v].y0 + vecs[v].h) push(vecs[v].exp, cyc + W + 3);
        if (y >= vecs[v].y0 && y < vecs[v].y0 + vecs[v].h) row(rmask(vecs[v].x0, vecs[v].w));
        else row(32'd0);
      end
      end_frame();
    end

    // Two disjoint blocks: slot 0 then slot 1 on consecutive cycles; busy window.
    start_frame();
    m = rmask(2, 2) | rmask(20, 2);
    row(m);
    row(m);
    pixels(32'd0, -1);
    t = cyc;
    push(mk(2, 3, 0, 1, 4), t + 3);
    push(mk(20, 21, 0, 1, 4), t + 4);
    line();
    check("scan_busy_rise", 64'(if_a.busy), 64'd1);
    blank(NS + 1);
    check("scan_busy_last", 64'(if_a.busy), 64'd1);
    blank(1);
    check("scan_busy_fall", 64'(if_a.busy), 64'd0);
    blank(2);
    end_frame();

    // Diagonal neighbours join.
    start_frame();
    row(32'd1 << 4);
    row(32'd1 << 5);
    push(mk(4, 5, 0, 1, 2), cyc + W + 3);
    row(32'd0);
    end_frame();

    // A pix_valid gap inside a run does not split it.
    start_frame();
    pixels(rmask(6, 4), 7);
    line();
    blank(NS + 4);
    push(mk(6, 9, 0, 0, 4), cyc + W + 3);
    row(32'd0);
    end_frame();

    // NSLOTS+1 single-pixel runs: last one dropped.
    start_frame();
    row(32'h0001_5555);
`ifdef OBJECT_EXTRACTOR_STATS_EN
    check("dropped_runs_a", 64'(dr_a), 64'd1);
    check("dropped_runs_b", 64'(dr_b), 64'd1);
`endif
    t = cyc;
    for (int i = 0; i < int'(NS); i++) push(mk(2 * i, 2 * i, 0, 0, 1), t + W + 3 + i);
    row(32'd0);
    end_frame();

    // buf_full across a scan closing three objects: no writes.
    start_frame();
    m = rmask(0, 2) | rmask(5, 2) | rmask(10, 2);
    row(m);
    row(m);
    buf_full = 1'b1;
    row(32'd0);
    buf_full = 1'b0;
`ifdef OBJECT_EXTRACTOR_STATS_EN
    check("dropped_objects_a", 64'(do_a), 64'd3);
    check("dropped_objects_b", 64'(do_b), 64'd3);
`endif
    end_frame();

    // Blob on the last row: written during flush, then frame_done.
    start_frame();
    row(rmask(3, 3));
    row(rmask(3, 3));
    t = cyc;
    push(mk(3, 5, 0, 1, 6), t + 2);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("flush_busy", 64'(if_b.busy), 64'd1);
    blank(NS);
    check("done_early", 64'(if_a.frame_done), 64'd0);
    blank(1);
    check("done_a", 64'(if_a.frame_done), 64'd1);
    check("done_b", 64'(if_b.frame_done), 64'd1);
    check("flush_busy_fall", 64'(if_a.busy), 64'd0);
    blank(1);
    check("done_pulse", 64'(if_a.frame_done), 64'd0);
    blank(2);

    // Reset in the middle of a scan.
    start_frame();
    m = rmask(0, 3) | rmask(20, 2);
    row(m);
    row(m);
    pixels(32'd0, -1);
    t = cyc;
    push(mk(0, 2, 0, 1, 6), t + 3);
    line();
    check("mid_busy", 64'(if_b.busy), 64'd1);
    blank(3);
    check("pre_reset_write_a", 64'(if_a.obj_write), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_write_a", 64'(if_a.obj_write), 64'd0);
    check("rst_write_b", 64'(if_b.obj_write), 64'd0);
    check("rst_busy_a", 64'(if_a.busy), 64'd0);
    check("rst_done_b", 64'(if_b.frame_done), 64'd0);
    blank(2);
    reset = 1'b0;
    blank(NS + 4);
    check("rst_idle_busy", 64'(if_a.busy), 64'd0);

    check("leftover_a", 64'(q_a.size()), 64'd0);
    check("leftover_b", 64'(q_b.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
